// File: rtl/tick_run_control.sv
// Run/pause/step control for the modulo-k counters: synchronizes and debounces three
// active-low keys, then drives a prescaled count-enable tick and a synchronous clear pulse.
module tick_run_control #(
    parameter int DIV       = 5_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_clr_n,
    output logic       tick,
    output logic       sclr,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    // Bit order for all key vectors: [2] clear, [1] step, [0] run.
    logic [2:0]          key_raw;
    logic [2:0]          sync_p0;
    logic [2:0]          sync_p1;
    logic [2:0]          db_lvl;
    logic [2:0]          db_lvl_d;
    logic [2:0][CW-1:0]  db_cnt;
    logic [2:0]          press;
    logic                run_ev;
    logic                step_ev;
    logic                clr_ev;

    state_t              state_q;
    state_t              state_nx;
    logic [PW-1:0]       pre_q;
    logic [PW-1:0]       pre_nx;
    logic                wrap;
    logic                tick_nx;
    logic                sclr_nx;

    assign key_raw = {key_clr_n, key_step_n, key_run_n};

    // Stage p0/p1: two-flop synchronizer, then debounce on the synchronized level.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            sync_p0  <= '1;
            sync_p1  <= '1;
            db_lvl   <= '1;
            db_lvl_d <= '1;
            db_cnt   <= '0;
        end else begin
            sync_p0  <= key_raw;
            sync_p1  <= sync_p0;
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= sync_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Only a debounced falling edge is a press; releases are silent.
    assign press   = db_lvl_d & ~db_lvl;
    assign run_ev  = press[0];
    assign step_ev = press[1];
    assign clr_ev  = press[2];

    assign wrap = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tick    <= 1'b0;
            sclr    <= 1'b0;
        end else begin
            state_q <= state_nx;
            pre_q   <= pre_nx;
            tick    <= tick_nx;
            sclr    <= sclr_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        pre_nx   = pre_q;
        tick_nx  = 1'b0;
        sclr_nx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_ev) begin
                    state_nx = RUN;
                end else if (step_ev) begin
                    tick_nx = 1'b1;
                end
            end
            RUN: begin
                // The prescaler advances even on the pausing cycle, so a coincident wrap still ticks.
                tick_nx = wrap;
                pre_nx  = wrap ? '0 : pre_q + 1'b1;
                if (run_ev) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (run_ev) begin
                    state_nx = RUN;
                end else if (step_ev) begin
                    tick_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                pre_nx   = '0;
            end
        endcase
        if (clr_ev) begin
            state_nx = IDLE;
            pre_nx   = '0;
            tick_nx  = 1'b0;
            sclr_nx  = 1'b1;
        end
    end

    assign state   = state_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_tick_run_control.sv
// Table-driven bench for tick_run_control with DIV=5, DB_CYCLES=4: each record holds key
// levels for N cycles and expects the end state plus tick/sclr counts seen over those cycles.
module tb_tick_run_control;

    localparam int DIV = 5;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       aclr;
    logic       key_run_n;
    logic       key_step_n;
    logic       key_clr_n;
    logic       tick;
    logic       sclr;
    logic       running;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic aclr;
        logic run_n;
        logic step_n;
        logic clr_n;
        int   n;
        int   st;
        int   nt;
        int   ns;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    tick_run_control #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .key_run_n (key_run_n),
        .key_step_n(key_step_n),
        .key_clr_n (key_clr_n),
        .tick      (tick),
        .sclr      (sclr),
        .running   (running),
        .state     (state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n, output int nt, output int ns, output int nb);
        nt = 0;
        ns = 0;
        nb = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            nt += int'(tick);
            ns += int'(sclr);
            nb += int'(tick & sclr);
        end
    endtask

    task automatic add(input logic a, input logic r, input logic s, input logic c,
                       input int n, input int st, input int nt, input int ns);
        vec_t v;
        v.aclr = a; v.run_n = r; v.step_n = s; v.clr_n = c;
        v.n = n; v.st = st; v.nt = nt; v.ns = ns;
        vecs.push_back(v);
    endtask

    initial begin
        int nt;
        int ns;
        int nb;
        aclr       = 1'b0;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        key_clr_n  = 1'b1;

        //   aclr run step clr  cycles state ticks sclrs
        add(0, 1, 1, 1,  3, 0, 0, 0);
        add(1, 1, 1, 1,  5, 0, 0, 0);
        add(1, 0, 1, 1,  6, 0, 0, 0);   // press not yet accepted
        add(1, 0, 1, 1,  1, 1, 0, 0);   // RUN at cycle 7
        add(1, 1, 1, 1, 20, 1, 4, 0);   // 4 ticks in 20 cycles
        add(1, 0, 1, 1,  7, 2, 1, 0);   // pause, prescaler frozen at 2
        add(1, 1, 1, 1, 10, 2, 0, 0);   // no ticks while paused
        add(1, 0, 1, 1,  7, 1, 0, 0);   // resume
        add(1, 1, 1, 1,  2, 1, 0, 0);
        add(1, 1, 1, 1,  1, 1, 1, 0);   // first tick 3 cycles after resume
        add(1, 1, 1, 1, 10, 1, 2, 0);
        add(1, 0, 1, 1,  7, 2, 1, 0);   // pause again
        add(1, 1, 1, 1,  8, 2, 0, 0);
        add(1, 1, 0, 1,  7, 2, 1, 0);   // step in PAUSE -> one tick
        add(1, 1, 0, 1,  5, 2, 0, 0);   // holding step -> nothing more
        add(1, 1, 1, 1,  8, 2, 0, 0);
        add(1, 0, 1, 1,  7, 1, 0, 0);   // resume from 2
        add(1, 1, 0, 1,  7, 1, 1, 0);   // step in RUN ignored
        add(1, 1, 1, 1,  9, 1, 2, 0);
        add(1, 0, 1, 0,  6, 1, 1, 0);   // run+clr together, prescaler at 4
        add(1, 0, 1, 0,  1, 0, 0, 1);   // clr wins, wrap tick suppressed
        add(1, 0, 1, 0, 10, 0, 0, 0);
        add(1, 1, 1, 1,  8, 0, 0, 0);
        add(1, 0, 1, 1,  7, 1, 0, 0);   // restart: prescaler was cleared
        add(1, 1, 1, 1,  4, 1, 0, 0);
        add(1, 1, 1, 1,  1, 1, 1, 0);
        add(1, 1, 1, 0,  7, 0, 1, 1);   // clr alone from RUN
        add(1, 1, 1, 1,  8, 0, 0, 0);
        add(1, 1, 0, 1,  7, 0, 1, 0);   // step in IDLE -> one tick
        add(1, 1, 1, 1,  8, 0, 0, 0);
        add(1, 0, 1, 1,  2, 0, 0, 0);   // bounce 0-1-0-1 in 2-cycle runs
        add(1, 1, 1, 1,  2, 0, 0, 0);
        add(1, 0, 1, 1,  2, 0, 0, 0);
        add(1, 1, 1, 1,  2, 0, 0, 0);
        add(1, 0, 1, 1,  6, 0, 0, 0);   // then held low
        add(1, 0, 1, 1,  1, 1, 0, 0);
        add(1, 1, 1, 1,  3, 1, 0, 0);
        add(1, 1, 1, 1,  1, 1, 0, 0);
        add(1, 1, 1, 1,  1, 1, 1, 0);   // tick high right now

        for (int i = 0; i < vecs.size(); i++) begin
            aclr       = vecs[i].aclr;
            key_run_n  = vecs[i].run_n;
            key_step_n = vecs[i].step_n;
            key_clr_n  = vecs[i].clr_n;
            run_cycles(vecs[i].n, nt, ns, nb);
            check($sformatf("v%0d_state", i), int'(state), vecs[i].st);
            check($sformatf("v%0d_running", i), int'(running), (vecs[i].st == 1) ? 1 : 0);
            check($sformatf("v%0d_ticks", i), nt, vecs[i].nt);
            check($sformatf("v%0d_sclrs", i), ns, vecs[i].ns);
            check($sformatf("v%0d_overlap", i), nb, 0);
        end

        // Asynchronous reset while a tick is high, away from any clock edge.
        check("pre_reset_tick", int'(tick), 1);
        #3;
        aclr = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_sclr", int'(sclr), 0);
        check("async_rst_running", int'(running), 0);
        run_cycles(2, nt, ns, nb);
        aclr = 1'b1;
        run_cycles(12, nt, ns, nb);
        check("post_rst_ticks", nt, 0);
        check("post_rst_sclrs", ns, 0);
        check("post_rst_state", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
